// File: rtl/csm_dual_port.sv
// csm_dual_port: 4x8 dual-port shared memory with per-address hold locks.
// Same-address collisions are arbitrated by a toggling priority pointer.
module csm_dual_port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_req,
    input  logic [2:0]             a_op,
    input  logic [ADDR_W-1:0]      a_addr,
    input  logic [DATA_W-1:0]      a_wdata,
    output logic                   a_ack,
    output logic [DATA_W-1:0]      a_rdata,
    output logic [1:0]             a_err,
    input  logic                   b_req,
    input  logic [2:0]             b_op,
    input  logic [ADDR_W-1:0]      b_addr,
    input  logic [DATA_W-1:0]      b_wdata,
    output logic                   b_ack,
    output logic [DATA_W-1:0]      b_rdata,
    output logic [1:0]             b_err,
    output logic [2**ADDR_W-1:0]   lock_a,
    output logic [2**ADDR_W-1:0]   lock_b
);
    localparam int DEPTH = 2**ADDR_W;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_HOLD = 3'd3;
    localparam logic [2:0] OP_REL  = 3'd4;

    localparam logic [1:0] E_OK   = 2'd0;
    localparam logic [1:0] E_LOCK = 2'd1;
    localparam logic [1:0] E_COLL = 2'd2;
    localparam logic [1:0] E_ILL  = 2'd3;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  lock_a_d;
    logic [DEPTH-1:0]  lock_b_d;
    logic              prio_q;
    logic              prio_d;
    logic              a_ack_d;
    logic              b_ack_d;
    logic [1:0]        a_err_d;
    logic [1:0]        b_err_d;
    logic [DATA_W-1:0] a_rdata_d;
    logic [DATA_W-1:0] b_rdata_d;

    logic same;
    logic a_mem;
    logic b_mem;
    logic a_rw;
    logic b_rw;
    logic rw_pair;
    logic conflict;

    // read+read and read+write on one address coexist; anything else mutating collides
    assign same     = a_req && b_req && (a_addr == b_addr);
    assign a_mem    = (a_op >= OP_RD) && (a_op <= OP_REL);
    assign b_mem    = (b_op >= OP_RD) && (b_op <= OP_REL);
    assign a_rw     = (a_op == OP_RD) || (a_op == OP_WR);
    assign b_rw     = (b_op == OP_RD) || (b_op == OP_WR);
    assign rw_pair  = a_rw && b_rw && !((a_op == OP_WR) && (b_op == OP_WR));
    assign conflict = same && a_mem && b_mem && !rw_pair;

    always_comb begin
        mem_d     = mem_q;
        lock_a_d  = lock_a;
        lock_b_d  = lock_b;
        prio_d    = conflict ? ~prio_q : prio_q;
        a_ack_d   = a_req;
        b_ack_d   = b_req;
        a_err_d   = E_OK;
        b_err_d   = E_OK;
        a_rdata_d = '0;
        b_rdata_d = '0;

        if (a_req) begin
            if (conflict && prio_q) begin
                a_err_d = E_COLL;
            end else begin
                unique case (a_op)
                    OP_NOP: begin end
                    OP_RD: begin
                        if (lock_b[a_addr]) a_err_d = E_LOCK;
                        else a_rdata_d = mem_q[a_addr];
                    end
                    OP_WR: begin
                        if (lock_b[a_addr]) a_err_d = E_LOCK;
                        else mem_d[a_addr] = a_wdata;
                    end
                    OP_HOLD: begin
                        if (lock_b[a_addr]) a_err_d = E_LOCK;
                        else lock_a_d[a_addr] = 1'b1;
                    end
                    OP_REL: begin
                        if (lock_a[a_addr]) lock_a_d[a_addr] = 1'b0;
                        else a_err_d = E_ILL;
                    end
                    default: a_err_d = E_ILL;
                endcase
            end
        end

        if (b_req) begin
            if (conflict && !prio_q) begin
                b_err_d = E_COLL;
            end else begin
                unique case (b_op)
                    OP_NOP: begin end
                    OP_RD: begin
                        if (lock_a[b_addr]) b_err_d = E_LOCK;
                        else b_rdata_d = mem_q[b_addr];
                    end
                    OP_WR: begin
                        if (lock_a[b_addr]) b_err_d = E_LOCK;
                        else mem_d[b_addr] = b_wdata;
                    end
                    OP_HOLD: begin
                        if (lock_a[b_addr]) b_err_d = E_LOCK;
                        else lock_b_d[b_addr] = 1'b1;
                    end
                    OP_REL: begin
                        if (lock_b[b_addr]) lock_b_d[b_addr] = 1'b0;
                        else b_err_d = E_ILL;
                    end
                    default: b_err_d = E_ILL;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            lock_a  <= '0;
            lock_b  <= '0;
            prio_q  <= 1'b0;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_err   <= E_OK;
            b_err   <= E_OK;
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            mem_q   <= mem_d;
            lock_a  <= lock_a_d;
            lock_b  <= lock_b_d;
            prio_q  <= prio_d;
            a_ack   <= a_ack_d;
            b_ack   <= b_ack_d;
            a_err   <= a_err_d;
            b_err   <= b_err_d;
            a_rdata <= a_rdata_d;
            b_rdata <= b_rdata_d;
        end
    end
endmodule

// File: tb/tb_csm_dual_port.sv
// tb_csm_dual_port: directed vector table plus randomized traffic
// checked against an ownership/array model of the shared memory.
module tb_csm_dual_port;
    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, b_req;
    logic [2:0] a_op, b_op;
    logic [1:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ack, b_ack;
    logic [7:0] a_rdata, b_rdata;
    logic [1:0] a_err, b_err;
    logic [3:0] lock_a, lock_b;

    always #5 clk = ~clk;

    csm_dual_port dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_op(a_op), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_op(b_op), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .lock_a(lock_a), .lock_b(lock_b)
    );

    typedef struct {
        logic       rst;
        logic       ar;
        logic [2:0] aop;
        logic [1:0] aad;
        logic [7:0] awd;
        logic       br;
        logic [2:0] bop;
        logic [1:0] bad;
        logic [7:0] bwd;
        logic       eaa;
        logic [1:0] eae;
        logic [7:0] ead;
        logic       eba;
        logic [1:0] ebe;
        logic [7:0] ebd;
        logic [3:0] ela;
        logic [3:0] elb;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // owner: 0 free, 1 port A, 2 port B; prio: 0 A, 1 B
    logic [7:0] m_mem [4];
    int         m_own [4];
    int         m_prio;
    logic [7:0] pre_mem [4];
    int         pre_own [4];

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic rst,
        input logic ar, input logic [2:0] aop,
        input logic [1:0] aad, input logic [7:0] awd,
        input logic br, input logic [2:0] bop,
        input logic [1:0] bad, input logic [7:0] bwd,
        input logic eaa, input logic [1:0] eae, input logic [7:0] ead,
        input logic eba, input logic [1:0] ebe, input logic [7:0] ebd,
        input logic [3:0] ela, input logic [3:0] elb);
        vec_t v;
        v.rst = rst;
        v.ar = ar; v.aop = aop; v.aad = aad; v.awd = awd;
        v.br = br; v.bop = bop; v.bad = bad; v.bwd = bwd;
        v.eaa = eaa; v.eae = eae; v.ead = ead;
        v.eba = eba; v.ebe = ebe; v.ebd = ebd;
        v.ela = ela; v.elb = elb;
        return v;
    endfunction

    function automatic bit is_mem_op(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    function automatic bit collides(input vec_t v);
        if (!(v.ar && v.br && v.aad == v.bad)) return 1'b0;
        if (!is_mem_op(v.aop) || !is_mem_op(v.bop)) return 1'b0;
        if (v.aop == 3'd1 && v.bop == 3'd1) return 1'b0;
        if (v.aop == 3'd1 && v.bop == 3'd2) return 1'b0;
        if (v.aop == 3'd2 && v.bop == 3'd1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic serve(input int me, input logic [2:0] op,
                         input int addr, input logic [7:0] wd,
                         output logic [1:0] err, output logic [7:0] rd);
        int other;
        other = (me == 1) ? 2 : 1;
        err = 2'd0;
        rd  = 8'd0;
        case (op)
            3'd0: begin end
            3'd1: if (pre_own[addr] == other) err = 2'd1;
                  else rd = pre_mem[addr];
            3'd2: if (pre_own[addr] == other) err = 2'd1;
                  else m_mem[addr] = wd;
            3'd3: if (pre_own[addr] == other) err = 2'd1;
                  else m_own[addr] = me;
            3'd4: if (pre_own[addr] == me) m_own[addr] = 0;
                  else err = 2'd3;
            default: err = 2'd3;
        endcase
    endtask

    task automatic model(inout vec_t v);
        bit coll;
        v.eaa = 1'b0; v.eae = 2'd0; v.ead = 8'd0;
        v.eba = 1'b0; v.ebe = 2'd0; v.ebd = 8'd0;
        if (v.rst) begin
            for (int i = 0; i < 4; i++) begin
                m_mem[i] = 8'd0;
                m_own[i] = 0;
            end
            m_prio = 0;
        end else begin
            pre_mem = m_mem;
            pre_own = m_own;
            coll = collides(v);
            v.eaa = v.ar;
            v.eba = v.br;
            if (v.ar) begin
                if (coll && m_prio == 1) v.eae = 2'd2;
                else serve(1, v.aop, int'(v.aad), v.awd, v.eae, v.ead);
            end
            if (v.br) begin
                if (coll && m_prio == 0) v.ebe = 2'd2;
                else serve(2, v.bop, int'(v.bad), v.bwd, v.ebe, v.ebd);
            end
            if (coll) m_prio = 1 - m_prio;
        end
        for (int i = 0; i < 4; i++) begin
            v.ela[i] = (m_own[i] == 1);
            v.elb[i] = (m_own[i] == 2);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input bit use_table, input string tag);
        vec_t m;
        vec_t x;
        m = v;
        reset = v.rst;
        a_req = v.ar; a_op = v.aop; a_addr = v.aad; a_wdata = v.awd;
        b_req = v.br; b_op = v.bop; b_addr = v.bad; b_wdata = v.bwd;
        model(m);
        x = use_table ? v : m;
        @(posedge clk);
        #1;
        chk({tag, ".a_ack"},   int'(a_ack),   int'(x.eaa));
        chk({tag, ".a_err"},   int'(a_err),   int'(x.eae));
        chk({tag, ".a_rdata"}, int'(a_rdata), int'(x.ead));
        chk({tag, ".b_ack"},   int'(b_ack),   int'(x.eba));
        chk({tag, ".b_err"},   int'(b_err),   int'(x.ebe));
        chk({tag, ".b_rdata"}, int'(b_rdata), int'(x.ebd));
        chk({tag, ".lock_a"},  int'(lock_a),  int'(x.ela));
        chk({tag, ".lock_b"},  int'(lock_b),  int'(x.elb));
    endtask

    initial begin
        vec_t r;
        reset = 1'b1;
        a_req = 0; a_op = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_op = 0; b_addr = 0; b_wdata = 0;
        for (int i = 0; i < 4; i++) begin
            m_mem[i] = 8'd0;
            m_own[i] = 0;
        end
        m_prio = 0;

        //            rst ar op ad wd    br op ad wd    ea ee ed    ba be bd    la    lb
        tbl.push_back(mk(1, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1,2,2,8'hA5, 0,0,0,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h0, 4'h0));
        tbl.push_back(mk(0, 0,0,0,8'h00, 1,1,2,8'h00, 0,0,8'h00, 1,0,8'hA5, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1,3,1,8'h00, 0,0,0,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h2, 4'h0));
        tbl.push_back(mk(0, 0,0,0,8'h00, 1,1,1,8'h00, 0,0,8'h00, 1,1,8'h00, 4'h2, 4'h0));
        tbl.push_back(mk(0, 0,0,0,8'h00, 1,2,1,8'hFF, 0,0,8'h00, 1,1,8'h00, 4'h2, 4'h0));
        tbl.push_back(mk(0, 1,1,1,8'h00, 0,0,0,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h2, 4'h0));
        tbl.push_back(mk(0, 1,2,3,8'h11, 1,2,3,8'h22, 1,0,8'h00, 1,2,8'h00, 4'h2, 4'h0));
        tbl.push_back(mk(0, 1,2,3,8'h11, 1,2,3,8'h22, 1,2,8'h00, 1,0,8'h00, 4'h2, 4'h0));
        tbl.push_back(mk(0, 1,1,3,8'h00, 0,0,0,8'h00, 1,0,8'h22, 0,0,8'h00, 4'h2, 4'h0));
        tbl.push_back(mk(0, 1,1,0,8'h00, 1,2,0,8'hFF, 1,0,8'h00, 1,0,8'h00, 4'h2, 4'h0));
        tbl.push_back(mk(0, 0,0,0,8'h00, 1,1,0,8'h00, 0,0,8'h00, 1,0,8'hFF, 4'h2, 4'h0));
        tbl.push_back(mk(0, 0,0,0,8'h00, 1,4,1,8'h00, 0,0,8'h00, 1,3,8'h00, 4'h2, 4'h0));
        tbl.push_back(mk(0, 1,4,1,8'h00, 0,0,0,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1,6,0,8'h00, 0,0,0,8'h00, 1,3,8'h00, 0,0,8'h00, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1,3,0,8'h00, 0,0,0,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h1, 4'h0));
        tbl.push_back(mk(0, 1,3,2,8'h00, 0,0,0,8'h00, 1,0,8'h00, 0,0,8'h00, 4'h5, 4'h0));
        tbl.push_back(mk(1, 0,0,0,8'h00, 1,2,1,8'h33, 0,0,8'h00, 0,0,8'h00, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1,1,0,8'h00, 1,1,1,8'h00, 1,0,8'h00, 1,0,8'h00, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1,1,2,8'h00, 1,1,3,8'h00, 1,0,8'h00, 1,0,8'h00, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1,2,1,8'h44, 1,2,1,8'h55, 1,0,8'h00, 1,2,8'h00, 4'h0, 4'h0));
        tbl.push_back(mk(0, 0,0,0,8'h00, 1,1,1,8'h00, 0,0,8'h00, 1,0,8'h44, 4'h0, 4'h0));
        tbl.push_back(mk(0, 0,0,0,8'h00, 1,3,3,8'h00, 0,0,8'h00, 1,0,8'h00, 4'h0, 4'h8));
        tbl.push_back(mk(0, 1,3,3,8'h00, 1,3,3,8'h00, 1,2,8'h00, 1,0,8'h00, 4'h0, 4'h8));
        tbl.push_back(mk(0, 1,2,3,8'h77, 1,1,3,8'h00, 1,1,8'h00, 1,0,8'h00, 4'h0, 4'h8));
        tbl.push_back(mk(0, 1,4,2,8'h00, 1,4,3,8'h00, 1,3,8'h00, 1,0,8'h00, 4'h0, 4'h0));
        tbl.push_back(mk(0, 1,0,1,8'h00, 1,0,1,8'h00, 1,0,8'h00, 1,0,8'h00, 4'h0, 4'h0));

        foreach (tbl[i]) run(tbl[i], 1'b1, $sformatf("vec%0d", i));

        r = mk(1, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 4'h0, 4'h0);
        run(r, 1'b0, "rnd_reset");
        for (int n = 0; n < 3000; n++) begin
            r.rst = ($urandom_range(0, 99) == 0);
            r.ar  = ($urandom_range(0, 4) != 0);
            r.aop = 3'($urandom_range(0, 7));
            r.aad = 2'($urandom_range(0, 3));
            r.awd = 8'($urandom);
            r.br  = ($urandom_range(0, 4) != 0);
            r.bop = 3'($urandom_range(0, 7));
            r.bad = 2'($urandom_range(0, 3));
            r.bwd = 8'($urandom);
            run(r, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/csm_dual_port.md
# csm_dual_port

Dual-port shared memory with per-address hold (lock) semantics: the responder that processors A and B drive through the CSM bus-functional model. It holds a 4-entry by 8-bit register file and serves read, write, hold and release commands from both ports. Collisions and lock violations are resolved deterministically and reported with an error code, so the random stimulus generator can check every response.

## Interface
- DATA_W, 8, data width of each entry
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries (4)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- a_req  in  1  port A command valid this cycle
- a_op  in  3  A command: 0 nop, 1 read, 2 write, 3 hold, 4 release, 5-7 illegal
- a_addr  in  ADDR_W  A target address
- a_wdata  in  DATA_W  A write data (ignored unless write)
- a_ack  out  1  A response valid (one-cycle pulse)
- a_rdata  out  DATA_W  A read data, valid with a_ack
- a_err  out  2  A status with a_ack: 0 ok, 1 locked by other port, 2 same-cycle collision lost, 3 illegal op / release not owned
- b_req, b_op, b_addr, b_wdata, b_ack, b_rdata, b_err: same as A for port B
- lock_a  out  DEPTH  bit i = address i held by A
- lock_b  out  DEPTH  bit i = address i held by B

## Operation
- State: mem[DEPTH], lock owner per address (none/A/B), priority pointer prio (A or B).
- A command is accepted on every rising edge with req=1. There is no backpressure. Each accepted command produces exactly one response.
- nop with req=1: ack with err=0, no state change.
- read: if the address is held by the other port, err=1 and rdata=0. Otherwise rdata = mem[addr], err=0.
- write: if the address is held by the other port, err=1 and memory is unchanged. Otherwise mem[addr] = wdata, err=0, rdata=0.
- hold:
  - Address free: the port becomes owner, err=0.
  - Already owned by the same port: err=0, no change.
  - Owned by the other port: err=1.
- A port may hold any number of addresses at the same time.
- release: if the port is the owner, the lock is cleared and err=0. If the address is unheld or owned by the other port, err=3 and nothing changes.
- Illegal op (5-7): err=3, no state change.
- Same-cycle interaction: applies when both req=1 with equal addresses.
  - read + read: both serviced, err=0.
  - read + write: both serviced. The read returns the pre-write value; the write lands.
  - Any other pair involving write, hold or release: the prio port is serviced normally. The other port gets err=2 with no effect. prio then toggles.
  - Lock checks for both ports use lock state from before the cycle.
- Different addresses: the two ports are fully independent.
- rdata is 0 whenever err != 0 or the op is not read.

## Timing
- Latency: response registered exactly 1 cycle after acceptance. A command at edge N gives ack high during cycle N+1.
- Back-to-back commands at consecutive edges produce back-to-back acks. Each response reflects all state updates from earlier edges.
- A write at edge N followed by a read of the same address at edge N+1 on either port returns the new data.
- lock_a and lock_b are registered and update in the same cycle as the ack of the hold or release.
- Reset (synchronous, checked at the edge):
  - Outputs: a_ack, b_ack = 0; a_err, b_err = 0; a_rdata, b_rdata = 0; lock_a, lock_b = 0.
  - State: all mem entries = 0; prio = A.
  - Reset takes precedence. A command presented at a reset edge is dropped and gets no ack in the following cycle.
- Reset mid-hold clears all locks. No pending responses survive reset.

## Test plan
- Reset, then A write addr 2 = 0xA5, then B read addr 2 -> B ack 1 cycle later with rdata=0xA5, err=0.
- A hold addr 1, then B read addr 1 and B write 0xFF to addr 1 -> both err=1, rdata=0. Then A read addr 1 -> err=0 and the original value is returned.
- Same cycle: A write addr 3 = 0x11 and B write addr 3 = 0x22, issued twice with prio starting at A.
  - First cycle: A ok, B err=2; mem[3]=0x11.
  - Second cycle: B ok, A err=2; mem[3]=0x22.
- Same cycle: A read and B write 0xFF to addr 0, with mem[0]=0x00 -> A rdata=0x00, then a following read returns 0xFF.
- Lock edge cases:
  - B releases addr 1 held by A -> err=3, lock_a[1] stays 1.
  - A releases addr 1 -> lock_a=0.
  - A op=6 -> err=3.
- A hold addr 0 and 2, reset asserted concurrently with a B write -> next cycle no acks, lock_a=0, all mem entries read back 0x00.
